// File: rtl/udp_pkg.sv
// Shared types and widths for the UDP parser front-end arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package udp_pkg;

  localparam int DATA_W = 256;
  localparam int RES_W  = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    XFER     = 2'd1,
    WAIT_RES = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/udp_parser_arbiter.sv
// Shares one packet parser between N_REQ sources, one whole packet and its result at a time.
// Latency: one arbitration cycle in IDLE, then beats and the result pass through combinationally.
// Backpressure: parser ready goes straight to the owning source; result ready comes straight from the owner.
module udp_parser_arbiter
  import udp_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int BEATS       = 64,
  parameter int RES_TIMEOUT = 256
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]       p_data_o,
  output logic                    p_valid_o,
  input  logic                    p_ready_i,
  input  logic [RES_W-1:0]        p_res_i,
  input  logic                    p_res_valid_i,
  output logic                    p_res_ready_o,
  output logic [RES_W-1:0]        res_data_o,
  output logic [N_REQ-1:0]        res_valid_o,
  input  logic [N_REQ-1:0]        res_ready_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    timeout_o
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TMO_W  = (RES_TIMEOUT > 1) ? $clog2(RES_TIMEOUT) : 1;
  localparam bit TMO_EN = (RES_TIMEOUT > 0);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((RES_TIMEOUT > 0) ? RES_TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic [N_REQ-1:0]  owner_oh;
  logic [IDX_W-1:0]  next_ptr;
  logic              beat_hs;
  logic              res_hs;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req (req_valid_i),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Owner decode, and where the next search starts once this owner retires.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    next_ptr          = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
  end

  // Next state plus all outputs; every output is gated by state so reset drives them to zero.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    p_data_o      = '0;
    p_valid_o     = 1'b0;
    req_ready_o   = '0;
    p_res_ready_o = 1'b0;
    res_data_o    = '0;
    res_valid_o   = '0;
    grant_o       = '0;
    timeout_o     = 1'b0;
    beat_hs       = 1'b0;
    res_hs        = 1'b0;

    case (state_q)
      IDLE: begin
        // Register the winner only; no beat moves in this cycle.
        if (|arb_gnt) begin
          owner_d    = arb_idx;
          beat_cnt_d = '0;
          state_d    = XFER;
        end
      end

      XFER: begin
        grant_o     = owner_oh;
        p_data_o    = req_data_i[int'(owner_q)*DATA_W +: DATA_W];
        p_valid_o   = req_valid_i[owner_q];
        req_ready_o = p_ready_i ? owner_oh : '0;
        beat_hs     = req_valid_i[owner_q] & p_ready_i;
        if (beat_hs) begin
          if (beat_cnt_q == BEAT_LAST) begin
            beat_cnt_d = '0;
            tmo_cnt_d  = '0;
            state_d    = WAIT_RES;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end

      WAIT_RES: begin
        grant_o       = owner_oh;
        res_data_o    = p_res_i;
        res_valid_o   = p_res_valid_i ? owner_oh : '0;
        p_res_ready_o = res_ready_i[owner_q];
        res_hs        = p_res_valid_i & res_ready_i[owner_q];
        // A handshake in the last allowed cycle still counts as a normal result.
        if (res_hs) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
          timeout_o = 1'b1;
          state_d   = IDLE;
          rr_ptr_d  = next_ptr;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any packet in flight and restarts the search at source 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

endmodule
